// File: rtl/ps2_line_assembler_if.sv
// Scan-byte input and line outputs of the PS/2 line assembler.
// slave = assembler side, master = receiver/interpreter side.
interface ps2_line_assembler_if #(
  parameter int LINE_CHARS = 32
);
  logic [7:0]              scan_code;
  logic                    scan_valid;
  logic [8*LINE_CHARS-1:0] input_line;
  logic                    line_ready;
  logic [8*LINE_CHARS-1:0] edit_line;
  logic [5:0]              edit_len;
  logic                    overflow;

  modport slave (
    input  scan_code, scan_valid,
    output input_line, line_ready,
    output edit_line, edit_len, overflow
  );

  modport master (
    output scan_code, scan_valid,
    input  input_line, line_ready,
    input  edit_line, edit_len, overflow
  );
endinterface

// File: rtl/ps2_line_assembler.sv
// PS/2 Set-2 scan codes -> uppercase ASCII edit buffer, commit on Enter.
// Optional PS2_KEYPAD_EN: keypad digits and keypad Enter (E0 5A).
module ps2_line_assembler #(
  parameter int LINE_CHARS = 32
) (
  input  logic clock,
  input  logic resetn,
  ps2_line_assembler_if.slave bus
);
  localparam int W = 8 * LINE_CHARS;
  localparam logic [5:0] FULL = 6'(LINE_CHARS);

  typedef enum logic [1:0] {
    IDLE, EXT, BRK, EXT_BRK
  } state_t;

  state_t         state;
  logic [W-1:0]   input_line;
  logic [W-1:0]   edit_line;
  logic [5:0]     edit_len;
  logic           line_ready;
  logic           overflow;

  logic [7:0]     ch;
  logic           hit_ch;
  logic           hit_enter;
  logic           hit_bs;

  function automatic logic [7:0] to_ascii(
    input logic [7:0] code
  );
    case (code)
      8'h1C: to_ascii = 8'h41;
      8'h32: to_ascii = 8'h42;
      8'h21: to_ascii = 8'h43;
      8'h23: to_ascii = 8'h44;
      8'h24: to_ascii = 8'h45;
      8'h2B: to_ascii = 8'h46;
      8'h34: to_ascii = 8'h47;
      8'h33: to_ascii = 8'h48;
      8'h43: to_ascii = 8'h49;
      8'h3B: to_ascii = 8'h4A;
      8'h42: to_ascii = 8'h4B;
      8'h4B: to_ascii = 8'h4C;
      8'h3A: to_ascii = 8'h4D;
      8'h31: to_ascii = 8'h4E;
      8'h44: to_ascii = 8'h4F;
      8'h4D: to_ascii = 8'h50;
      8'h15: to_ascii = 8'h51;
      8'h2D: to_ascii = 8'h52;
      8'h1B: to_ascii = 8'h53;
      8'h2C: to_ascii = 8'h54;
      8'h3C: to_ascii = 8'h55;
      8'h2A: to_ascii = 8'h56;
      8'h1D: to_ascii = 8'h57;
      8'h22: to_ascii = 8'h58;
      8'h35: to_ascii = 8'h59;
      8'h1A: to_ascii = 8'h5A;
      8'h45: to_ascii = 8'h30;
      8'h16: to_ascii = 8'h31;
      8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33;
      8'h25: to_ascii = 8'h34;
      8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36;
      8'h3D: to_ascii = 8'h37;
      8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      8'h29: to_ascii = 8'h20;
`ifdef PS2_KEYPAD_EN
      8'h70: to_ascii = 8'h30;
      8'h69: to_ascii = 8'h31;
      8'h72: to_ascii = 8'h32;
      8'h7A: to_ascii = 8'h33;
      8'h6B: to_ascii = 8'h34;
      8'h73: to_ascii = 8'h35;
      8'h74: to_ascii = 8'h36;
      8'h6C: to_ascii = 8'h37;
      8'h75: to_ascii = 8'h38;
      8'h7D: to_ascii = 8'h39;
`endif
      default: to_ascii = 8'h00;
    endcase
  endfunction

  // Every printable mapping is nonzero, so 00 means "not a character".
  always_comb begin
    ch        = 8'h00;
    hit_ch    = 1'b0;
    hit_enter = 1'b0;
    hit_bs    = 1'b0;
    if (bus.scan_valid) begin
      case (state)
        IDLE: begin
          if (bus.scan_code != 8'hE0 &&
              bus.scan_code != 8'hF0) begin
            ch        = to_ascii(bus.scan_code);
            hit_ch    = (ch != 8'h00);
            hit_enter = (bus.scan_code == 8'h5A);
            hit_bs    = (bus.scan_code == 8'h66);
          end
        end
`ifdef PS2_KEYPAD_EN
        EXT: hit_enter = (bus.scan_code == 8'h5A);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      input_line <= '0;
      edit_line  <= '0;
      edit_len   <= 6'd0;
      line_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      line_ready <= 1'b0;
      if (bus.scan_valid) begin
        case (state)
          IDLE: begin
            if (bus.scan_code == 8'hE0)
              state <= EXT;
            else if (bus.scan_code == 8'hF0)
              state <= BRK;
          end
          EXT: begin
            if (bus.scan_code == 8'hF0)
              state <= EXT_BRK;
            else
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (hit_enter) begin
        input_line <= edit_line;
        line_ready <= 1'b1;
        edit_line  <= '0;
        edit_len   <= 6'd0;
        overflow   <= 1'b0;
      end else if (hit_bs) begin
        if (edit_len != 6'd0) begin
          edit_len <= edit_len - 6'd1;
          for (int i = 0; i < LINE_CHARS; i++)
            if (6'(i) == edit_len - 6'd1)
              edit_line[W-1-8*i -: 8] <= 8'h00;
        end
      end else if (hit_ch) begin
        if (edit_len < FULL) begin
          edit_len <= edit_len + 6'd1;
          for (int i = 0; i < LINE_CHARS; i++)
            if (6'(i) == edit_len)
              edit_line[W-1-8*i -: 8] <= ch;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.input_line = input_line;
  assign bus.line_ready = line_ready;
  assign bus.edit_line  = edit_line;
  assign bus.edit_len   = edit_len;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_ps2_line_assembler.sv
// Random and directed scan-code streams against a queue-based line model.
// Build with +define+PS2_KEYPAD_EN to also cover the keypad feature.
module tb_ps2_line_assembler;
  localparam int N = 32;
`ifdef PS2_KEYPAD_EN
  localparam bit KP = 1'b1;
`else
  localparam bit KP = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ps2_line_assembler_if #(.LINE_CHARS(N)) bus();
  ps2_line_assembler #(.LINE_CHARS(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [255:0] got,
                     logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  byte unsigned letters[26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digits[10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  byte unsigned kpad[10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
    8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  byte unsigned junk[6] = '{
    8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF};
  byte unsigned arrows[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  // Reference model: text as a queue of characters.
  byte unsigned q[$];
  logic         m_ovf;
  logic [255:0] m_line;
  bit           m_ready;
  bit           m_ext;
  bit           m_skip;

  function automatic int lookup(byte unsigned b);
    for (int i = 0; i < 26; i++)
      if (letters[i] == b) return 8'h41 + i;
    for (int i = 0; i < 10; i++)
      if (digits[i] == b) return 8'h30 + i;
    if (b == 8'h29) return 8'h20;
    if (KP)
      for (int i = 0; i < 10; i++)
        if (kpad[i] == b) return 8'h30 + i;
    return -1;
  endfunction

  function automatic logic [255:0] pack();
    logic [255:0] v = '0;
    for (int i = 0; i < q.size(); i++)
      v[255-8*i -: 8] = q[i];
    return v;
  endfunction

  task automatic m_commit();
    m_line = pack();
    q.delete();
    m_ovf = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic model_byte(byte unsigned b);
    int a;
    m_ready = 1'b0;
    if (m_skip) begin
      m_skip = 1'b0;
    end else if (m_ext) begin
      m_ext = 1'b0;
      if (b == 8'hF0) m_skip = 1'b1;
      else if (KP && b == 8'h5A) m_commit();
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_skip = 1'b1;
    end else if (b == 8'h5A) begin
      m_commit();
    end else if (b == 8'h66) begin
      if (q.size() > 0) void'(q.pop_back());
    end else begin
      a = lookup(b);
      if (a >= 0) begin
        if (q.size() < N) q.push_back(byte'(a));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("edit_len", 256'(bus.edit_len), 256'(q.size()));
    chk("edit_line", bus.edit_line, pack());
    chk("overflow", 256'(bus.overflow), 256'(m_ovf));
    chk("line_ready", 256'(bus.line_ready), 256'(m_ready));
    chk("input_line", bus.input_line, m_line);
  endtask

  task automatic send(byte unsigned b);
    @(negedge clock);
    bus.scan_code = b;
    bus.scan_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.scan_valid = 1'b0;
    model_byte(b);
    check_all();
  endtask

  task automatic key(byte unsigned b, bit ext = 1'b0);
    if (ext) send(8'hE0);
    send(b);
    if (ext) send(8'hE0);
    send(8'hF0);
    send(b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_line = '0;
    m_ready = 1'b0;
    m_ext = 1'b0;
    m_skip = 1'b0;
    check_all();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int r;
    bus.scan_code = 8'h00;
    bus.scan_valid = 1'b0;
    do_reset();

    // "SET A 045" + Enter
    key(8'h1B); key(8'h24); key(8'h2C); key(8'h29);
    key(8'h1C); key(8'h29); key(8'h45); key(8'h25);
    key(8'h2E); key(8'h5A);
    chk("basic_line", bus.input_line,
        {72'h534554204120303435, 184'h0});
    chk("basic_len", 256'(bus.edit_len), 256'd0);

    // break and extended filtering
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75); send(8'hE0);
    send(8'hF0); send(8'h75);
    chk("filt_len", 256'(bus.edit_len), 256'd1);
    chk("filt_char", 256'(bus.edit_line[255:248]), 256'h41);
    key(8'h5A);

    // FIX, backspace, RE, Enter
    key(8'h2B); key(8'h43); key(8'h22); key(8'h66);
    key(8'h2D); key(8'h24); key(8'h5A);
    chk("bs_line", 256'(bus.input_line[255:224]),
        256'h46495245);
    key(8'h66);
    chk("bs_empty", 256'(bus.edit_len), 256'd0);

    // overflow
    repeat (33) key(8'h1C);
    chk("ovf_len", 256'(bus.edit_len), 256'd32);
    chk("ovf_flag", 256'(bus.overflow), 256'd1);
    chk("ovf_buf", bus.edit_line, {32{8'h41}});
    key(8'h5A);
    chk("ovf_line", bus.input_line, {32{8'h41}});
    chk("ovf_clr", 256'(bus.overflow), 256'd0);

    // reset mid-line
    repeat (5) key(8'h32);
    do_reset();
    chk("rst_len", 256'(bus.edit_len), 256'd0);

`ifdef PS2_KEYPAD_EN
    key(8'h2A); key(8'h7D); key(8'h70);
    send(8'hE0); send(8'h5A);
    chk("kp_ready", 256'(bus.line_ready), 256'd1);
    chk("kp_line", 256'(bus.input_line[255:232]),
        256'h563930);
    send(8'hE0); send(8'hF0); send(8'h5A);
`endif

    // random keystrokes
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55)
        key(letters[$urandom_range(0, 25)]);
      else if (r < 70)
        key(digits[$urandom_range(0, 9)]);
      else if (r < 76)
        key(8'h29);
      else if (r < 79)
        key(8'h5A, $urandom_range(0, 1) == 1);
      else if (r < 87)
        key(8'h66);
      else if (r < 91)
        key(arrows[$urandom_range(0, 3)], 1'b1);
      else if (r < 95)
        key(kpad[$urandom_range(0, 9)]);
      else if (r < 98)
        send(junk[$urandom_range(0, 5)]);
      else
        send(8'($urandom));
    end

    // hold check: outputs stable with no input
    repeat (3) @(posedge clock);
    #1;
    m_ready = 1'b0;
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
